// File: rtl/beta_bus_pkg.sv
// Shared types and constants for the Beta memory-bus decoder.
`timescale 1ns/1ps
package beta_bus_pkg;

    // Access sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2,
        ERR  = 2'd3
    } bus_state_e;

    // Default region map
    localparam int REGION_RAM       = 0;
    localparam int REGION_IO        = 1;
    localparam int REGION_RD_SHARED = 2;
    localparam int REGION_WR_SHARED = 3;

    // Width of the slave-ready timeout counter
    localparam int TMO_W = 8;

endpackage

// File: rtl/beta_region_decode.sv
// Region index to one-hot select decoder with a mapped/unmapped flag.
`timescale 1ns/1ps
module beta_region_decode #(
    parameter int N_REGIONS = 4,
    parameter int IDX_W     = 15
) (
    input  logic [IDX_W-1:0]     idx,
    output logic [N_REGIONS-1:0] onehot,
    output logic                 mapped
);

    // Unsigned compare of the index against each region and the region count
    always_comb begin
        onehot = '0;
        for (int r = 0; r < N_REGIONS; r++) begin
            onehot[r] = (idx == IDX_W'(r));
        end
        mapped = ({1'b0, idx} < (IDX_W + 1)'(N_REGIONS));
    end

endmodule

// File: rtl/beta_bus_decode.sv
// Beta data-port bus decoder: region select, wait states, slave-ready
// timeout and sticky unmapped-address error with interrupt.
`timescale 1ns/1ps
module beta_bus_decode
    import beta_bus_pkg::*;
#(
    parameter int                          DATA_W      = 32,
    parameter int                          N_REGIONS   = 4,
    parameter int                          SEL_HI      = 30,
    parameter int                          SEL_LO      = 16,
    parameter int                          WS_W        = 4,
    parameter logic [N_REGIONS*WS_W-1:0]   WAIT_STATES = '0,
    parameter int                          TIMEOUT     = 255
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [31:0]                   cpu_addr,
    input  logic                          cpu_req,
    input  logic                          cpu_we,
    output logic [DATA_W-1:0]             cpu_rdata,
    output logic                          cpu_ready,
    output logic [N_REGIONS-1:0]          sel,
    output logic                          slave_we,
    input  logic [N_REGIONS*DATA_W-1:0]   slave_rdata,
    input  logic [N_REGIONS-1:0]          slave_ready,
    output logic                          bus_err_irq,
    output logic [31:0]                   err_addr,
    input  logic                          err_clr
);

    localparam int IDX_W = SEL_HI - SEL_LO + 1;
    localparam logic [TMO_W-1:0] TMO_ONE = TMO_W'(1);
    localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TIMEOUT);
    localparam logic [WS_W-1:0]  WS_ONE  = WS_W'(1);

    if ((2 ** IDX_W) < N_REGIONS) begin : g_sel_too_narrow
        $error("beta_bus_decode: region index field cannot address N_REGIONS regions");
    end

    bus_state_e               state_q, state_d;
    logic [IDX_W-1:0]         idx;
    logic [N_REGIONS-1:0]     dec_onehot;
    logic                     dec_mapped;
    logic                     start;
    logic [31:0]              addr_q;
    logic [WS_W-1:0]          cnt_q, cnt_d;
    logic [TMO_W-1:0]         tmo_q, tmo_d;
    logic [WS_W-1:0]          ws_sel;
    logic [DATA_W-1:0]        rd_mux;
    logic                     rdy_mux;
    logic                     tmo_expire;
    logic [N_REGIONS-1:0]     sel_d;
    logic                     ready_d;
    logic [DATA_W-1:0]        rdata_d;
    logic                     we_d;
    logic                     irq_d;
    logic [31:0]              eaddr_d;

    // Supervisor bit addr[31] lies outside the index field and is ignored
    assign idx = cpu_addr[SEL_HI:SEL_LO];

    // A new access is accepted only from IDLE and never in a completion
    // cycle, so a request still held high on the ack does not re-trigger
    assign start = (state_q == IDLE) && cpu_req && !cpu_ready;

    // Timeout fires on the cycle the slave-ready wait count reaches TIMEOUT
    assign tmo_expire = ((tmo_q + TMO_ONE) == TMO_LIM);

    beta_region_decode #(
        .N_REGIONS (N_REGIONS),
        .IDX_W     (IDX_W)
    ) u_region_decode (
        .idx    (idx),
        .onehot (dec_onehot),
        .mapped (dec_mapped)
    );

    // Wait-state count of the region being decoded this cycle
    always_comb begin
        ws_sel = '0;
        for (int r = 0; r < N_REGIONS; r++) begin
            if (dec_onehot[r]) begin
                ws_sel = WAIT_STATES[r*WS_W +: WS_W];
            end
        end
    end

    // Read data and ready of the selected slave; sel is one-hot during an access
    always_comb begin
        rd_mux  = '0;
        rdy_mux = 1'b0;
        for (int r = 0; r < N_REGIONS; r++) begin
            if (sel[r]) begin
                rd_mux  = rd_mux | slave_rdata[r*DATA_W +: DATA_W];
                rdy_mux = rdy_mux | slave_ready[r];
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = dec_mapped ? WAIT : ERR;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    if (rdy_mux) begin
                        state_d = ACK;
                    end else if (tmo_expire) begin
                        state_d = ERR;
                    end
                end
            end
            ACK:     state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs and counters
    always_comb begin
        sel_d   = sel;
        ready_d = 1'b0;
        rdata_d = cpu_rdata;
        we_d    = slave_we;
        irq_d   = bus_err_irq & ~err_clr;
        eaddr_d = err_addr;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    we_d = cpu_we;
                    if (dec_mapped) begin
                        sel_d = dec_onehot;
                        cnt_d = ws_sel;
                        tmo_d = '0;
                    end
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - WS_ONE;
                end else if (rdy_mux) begin
                    ready_d = 1'b1;
                    rdata_d = slave_we ? '0 : rd_mux;
                end else begin
                    tmo_d = tmo_q + TMO_ONE;
                end
            end
            ACK: begin
                sel_d = '0;
            end
            ERR: begin
                ready_d = 1'b1;
                rdata_d = '0;
                sel_d   = '0;
                // First unacknowledged error wins; a clear in this same
                // cycle frees the slot so the new error is recorded
                if (!bus_err_irq || err_clr) begin
                    irq_d   = 1'b1;
                    eaddr_d = addr_q;
                end
            end
            default: begin
                sel_d = '0;
            end
        endcase
    end

    // Output and counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel         <= '0;
            cpu_ready   <= 1'b0;
            cpu_rdata   <= '0;
            slave_we    <= 1'b0;
            bus_err_irq <= 1'b0;
            err_addr    <= '0;
            cnt_q       <= '0;
            tmo_q       <= '0;
        end else begin
            sel         <= sel_d;
            cpu_ready   <= ready_d;
            cpu_rdata   <= rdata_d;
            slave_we    <= we_d;
            bus_err_irq <= irq_d;
            err_addr    <= eaddr_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
        end
    end

    // Access address captured when a request is accepted
    always_ff @(posedge clk) begin
        if (start) begin
            addr_q <= cpu_addr;
        end
    end

endmodule

// File: tb/tb_beta_bus_decode.sv
// Self-checking bench for beta_bus_decode with a transaction-level model.
`timescale 1ns/1ps
module tb_beta_bus_decode;

    localparam int DATA_W = 32;
    localparam int NR     = 4;
    localparam int TMO    = 8;
    localparam logic [15:0] WS_VEC = 16'h0210;  // r0=0, r1=1, r2=2, r3=0

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [31:0]       cpu_addr = '0;
    logic              cpu_req = 1'b0;
    logic              cpu_we = 1'b0;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ready;
    logic [NR-1:0]     sel;
    logic              slave_we;
    logic [NR*DATA_W-1:0] slave_rdata = '0;
    logic [NR-1:0]     slave_ready = '0;
    logic              bus_err_irq;
    logic [31:0]       err_addr;
    logic              err_clr = 1'b0;

    int total = 0;
    int bad = 0;

    int          ws_tab[NR] = '{0, 1, 2, 0};
    logic [31:0] rdata_tab[NR];
    bit          m_irq;
    logic [31:0] m_eaddr;

    int          o_lat;
    logic [31:0] o_rd;
    logic [3:0]  o_sel;
    int          e_lat;
    logic [31:0] e_rd;
    logic [3:0]  e_sel;

    beta_bus_decode #(
        .DATA_W      (DATA_W),
        .N_REGIONS   (NR),
        .SEL_HI      (30),
        .SEL_LO      (16),
        .WS_W        (4),
        .WAIT_STATES (WS_VEC),
        .TIMEOUT     (TMO)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cpu_addr    (cpu_addr),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_rdata   (cpu_rdata),
        .cpu_ready   (cpu_ready),
        .sel         (sel),
        .slave_we    (slave_we),
        .slave_rdata (slave_rdata),
        .slave_ready (slave_ready),
        .bus_err_irq (bus_err_irq),
        .err_addr    (err_addr),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic load_data();
        for (int r = 0; r < NR; r++) rdata_tab[r] = $urandom;
    endtask

    // Expected outcome of one access from the access rules
    task automatic model(input logic [31:0] a, input logic we, input int dly, input bit clr_at_err);
        int idx;
        bit err;
        idx = int'(a[30:16]);
        err = 1'b0;
        if (idx >= NR) begin
            e_lat = 2; e_rd = '0; e_sel = '0; err = 1'b1;
        end else begin
            e_sel = 4'(1 << idx);
            if (dly < TMO) begin
                e_lat = ws_tab[idx] + 2 + dly;
                e_rd  = we ? 32'h0 : rdata_tab[idx];
            end else begin
                e_lat = ws_tab[idx] + 2 + TMO;
                e_rd  = '0;
                err   = 1'b1;
            end
        end
        if (err && (!m_irq || clr_at_err)) begin
            m_irq = 1'b1;
            m_eaddr = a;
        end
    endtask

    // Drive one access; slave ready rises dly cycles after the wait states
    task automatic run_access(input logic [31:0] a, input logic we, input int dly,
                              input int clr_cycle, input bit hold_req);
        int c;
        int tgt;
        int rdy_at;
        tgt = int'(a[30:16]);
        rdy_at = (tgt < NR) ? ws_tab[tgt] + 1 + dly : 0;
        for (int r = 0; r < NR; r++) slave_rdata[r*DATA_W +: DATA_W] = rdata_tab[r];
        @(posedge clk); #1;
        c = 0;
        cpu_addr = a; cpu_we = we; cpu_req = 1'b1;
        slave_ready = 4'($urandom);
        if (tgt < NR) slave_ready[tgt] = (c >= rdy_at);
        err_clr = (c == clr_cycle);
        o_lat = -1; o_rd = '0; o_sel = '0;
        while (c < 40 && o_lat < 0) begin
            @(posedge clk); #1;
            c++;
            if (c == 2 && !hold_req) begin
                cpu_addr = $urandom;
                cpu_we = 1'($urandom);
            end
            slave_ready = 4'($urandom);
            if (tgt < NR) slave_ready[tgt] = (c >= rdy_at);
            err_clr = (c == clr_cycle);
            o_sel = o_sel | sel;
            if (cpu_ready) begin
                o_lat = c;
                o_rd = cpu_rdata;
            end
        end
        if (hold_req) begin
            @(posedge clk); #1;
        end
        cpu_req = 1'b0;
        err_clr = 1'b0;
        slave_ready = '0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (sel !== 4'b0) begin bad++; $display("FAIL rst_sel: got %b want 0000", sel); end
        total++; if (cpu_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", cpu_ready); end
        total++; if (cpu_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata: got %h want 0", cpu_rdata); end
        total++; if (slave_we !== 1'b0) begin bad++; $display("FAIL rst_slave_we: got %b want 0", slave_we); end
        total++; if (bus_err_irq !== 1'b0) begin bad++; $display("FAIL rst_irq: got %b want 0", bus_err_irq); end
        total++; if (err_addr !== 32'h0) begin bad++; $display("FAIL rst_err_addr: got %h want 0", err_addr); end
        reset_n = 1'b1;
        m_irq = 1'b0;
        m_eaddr = '0;
    endtask

    task automatic test_directed();
        load_data();
        rdata_tab[1] = 32'h0000_CAFE;
        run_access(32'h0001_0004, 1'b0, 0, -1, 1'b0);
        total++; if (o_sel !== 4'b0010) begin bad++; $display("FAIL d1_sel: got %b want 0010", o_sel); end
        total++; if (o_lat != 3) begin bad++; $display("FAIL d1_lat: got %0d want 3", o_lat); end
        total++; if (o_rd !== 32'h0000_CAFE) begin bad++; $display("FAIL d1_rdata: got %h want 0000cafe", o_rd); end

        load_data();
        run_access(32'h8000_0010, 1'b0, 0, -1, 1'b0);
        total++; if (o_sel !== 4'b0001) begin bad++; $display("FAIL d2_sel: got %b want 0001", o_sel); end
        total++; if (o_lat != 2) begin bad++; $display("FAIL d2_lat: got %0d want 2", o_lat); end
        total++; if (o_rd !== rdata_tab[0]) begin bad++; $display("FAIL d2_rdata: got %h want %h", o_rd, rdata_tab[0]); end

        run_access(32'h0007_0000, 1'b1, 0, -1, 1'b0);
        total++; if (o_sel !== 4'b0000) begin bad++; $display("FAIL d3_sel: got %b want 0000", o_sel); end
        total++; if (o_lat != 2) begin bad++; $display("FAIL d3_lat: got %0d want 2", o_lat); end
        total++; if (o_rd !== 32'h0) begin bad++; $display("FAIL d3_rdata: got %h want 0", o_rd); end
        total++; if (bus_err_irq !== 1'b1) begin bad++; $display("FAIL d3_irq: got %b want 1", bus_err_irq); end
        total++; if (err_addr !== 32'h0007_0000) begin bad++; $display("FAIL d3_err_addr: got %h want 00070000", err_addr); end
        total++; if (slave_we !== 1'b1) begin bad++; $display("FAIL d3_slave_we: got %b want 1", slave_we); end

        run_access(32'h0009_0000, 1'b0, 0, -1, 1'b0);
        total++; if (o_lat != 2) begin bad++; $display("FAIL d4_lat: got %0d want 2", o_lat); end
        total++; if (err_addr !== 32'h0007_0000) begin bad++; $display("FAIL d4_err_addr: got %h want 00070000", err_addr); end
        total++; if (bus_err_irq !== 1'b1) begin bad++; $display("FAIL d4_irq: got %b want 1", bus_err_irq); end
        @(posedge clk); #1; err_clr = 1'b1;
        @(posedge clk); #1; err_clr = 1'b0;
        total++; if (bus_err_irq !== 1'b0) begin bad++; $display("FAIL d4_clr_irq: got %b want 0", bus_err_irq); end
        total++; if (err_addr !== 32'h0007_0000) begin bad++; $display("FAIL d4_clr_addr: got %h want 00070000", err_addr); end
        m_irq = 1'b0;
        m_eaddr = 32'h0007_0000;
    endtask

    task automatic test_timeout();
        load_data();
        run_access(32'h0002_0040, 1'b0, TMO - 1, -1, 1'b0);
        total++; if (o_lat != 2 + 2 + TMO - 1) begin bad++; $display("FAIL tmo_edge_lat: got %0d want %0d", o_lat, 2 + 2 + TMO - 1); end
        total++; if (o_rd !== rdata_tab[2]) begin bad++; $display("FAIL tmo_edge_rdata: got %h want %h", o_rd, rdata_tab[2]); end
        total++; if (bus_err_irq !== 1'b0) begin bad++; $display("FAIL tmo_edge_irq: got %b want 0", bus_err_irq); end

        run_access(32'h0002_0000, 1'b0, 100, -1, 1'b0);
        total++; if (o_lat != 2 + TMO + 2) begin bad++; $display("FAIL tmo_lat: got %0d want %0d", o_lat, 2 + TMO + 2); end
        total++; if (o_sel !== 4'b0100) begin bad++; $display("FAIL tmo_sel: got %b want 0100", o_sel); end
        total++; if (o_rd !== 32'h0) begin bad++; $display("FAIL tmo_rdata: got %h want 0", o_rd); end
        total++; if (bus_err_irq !== 1'b1) begin bad++; $display("FAIL tmo_irq: got %b want 1", bus_err_irq); end
        total++; if (err_addr !== 32'h0002_0000) begin bad++; $display("FAIL tmo_err_addr: got %h want 00020000", err_addr); end
        m_irq = 1'b1;
        m_eaddr = 32'h0002_0000;
    endtask

    task automatic test_clr_vs_set();
        model(32'h0005_1234, 1'b1, 0, 1'b1);
        run_access(32'h0005_1234, 1'b1, 0, 1, 1'b0);
        total++; if (o_lat != e_lat) begin bad++; $display("FAIL clrset_lat: got %0d want %0d", o_lat, e_lat); end
        total++; if (bus_err_irq !== m_irq) begin bad++; $display("FAIL clrset_irq: got %b want %b", bus_err_irq, m_irq); end
        total++; if (err_addr !== m_eaddr) begin bad++; $display("FAIL clrset_err_addr: got %h want %h", err_addr, m_eaddr); end
    endtask

    task automatic test_hold_req();
        int extra;
        model(32'h0006_0000, 1'b0, 0, 1'b0);
        run_access(32'h0006_0000, 1'b0, 0, -1, 1'b1);
        extra = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (cpu_ready) extra++;
        end
        total++; if (o_lat != e_lat) begin bad++; $display("FAIL hold_lat: got %0d want %0d", o_lat, e_lat); end
        total++; if (extra != 0) begin bad++; $display("FAIL hold_retrigger: got %0d extra ready pulses want 0", extra); end
        total++; if (err_addr !== m_eaddr) begin bad++; $display("FAIL hold_err_addr: got %h want %h", err_addr, m_eaddr); end
    endtask

    task automatic test_reset_mid();
        load_data();
        for (int r = 0; r < NR; r++) slave_rdata[r*DATA_W +: DATA_W] = rdata_tab[r];
        @(posedge clk); #1;
        cpu_addr = 32'h0002_0000; cpu_we = 1'b0; cpu_req = 1'b1; slave_ready = '0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (sel !== 4'b0100) begin bad++; $display("FAIL midrst_sel_before: got %b want 0100", sel); end
        #2 reset_n = 1'b0;
        #1;
        total++; if (sel !== 4'b0000) begin bad++; $display("FAIL midrst_sel: got %b want 0000", sel); end
        total++; if (cpu_ready !== 1'b0) begin bad++; $display("FAIL midrst_ready: got %b want 0", cpu_ready); end
        total++; if (bus_err_irq !== 1'b0) begin bad++; $display("FAIL midrst_irq: got %b want 0", bus_err_irq); end
        cpu_req = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        m_irq = 1'b0;
        m_eaddr = '0;
        run_access(32'h0000_0100, 1'b0, 0, -1, 1'b0);
        total++; if (o_lat != 2) begin bad++; $display("FAIL midrst_next_lat: got %0d want 2", o_lat); end
        total++; if (o_rd !== rdata_tab[0]) begin bad++; $display("FAIL midrst_next_rdata: got %h want %h", o_rd, rdata_tab[0]); end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic        we;
        int          dly;
        for (int i = 0; i < 40; i++) begin
            a = {1'($urandom), 15'($urandom_range(0, 5)), 16'($urandom)};
            we = 1'($urandom);
            dly = $urandom_range(0, 9);
            load_data();
            model(a, we, dly, 1'b0);
            run_access(a, we, dly, -1, 1'b0);
            total++; if (o_lat != e_lat) begin bad++; $display("FAIL rnd_lat[%0d]: got %0d want %0d", i, o_lat, e_lat); end
            total++; if (o_rd !== e_rd) begin bad++; $display("FAIL rnd_rdata[%0d]: got %h want %h", i, o_rd, e_rd); end
            total++; if (o_sel !== e_sel) begin bad++; $display("FAIL rnd_sel[%0d]: got %b want %b", i, o_sel, e_sel); end
            total++; if (slave_we !== we) begin bad++; $display("FAIL rnd_slave_we[%0d]: got %b want %b", i, slave_we, we); end
            total++; if (bus_err_irq !== m_irq) begin bad++; $display("FAIL rnd_irq[%0d]: got %b want %b", i, bus_err_irq, m_irq); end
            total++; if (err_addr !== m_eaddr) begin bad++; $display("FAIL rnd_err_addr[%0d]: got %h want %h", i, err_addr, m_eaddr); end
            if (i % 5 == 4) begin
                @(posedge clk); #1; err_clr = 1'b1;
                @(posedge clk); #1; err_clr = 1'b0;
                m_irq = 1'b0;
                total++; if (bus_err_irq !== 1'b0) begin bad++; $display("FAIL rnd_clr[%0d]: got %b want 0", i, bus_err_irq); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_timeout();
        test_clr_vs_set();
        test_hold_req();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
